operand_fetch: RTL and testbench

- Operand-fetch stage directly upstream of the 16-bit ALU. Holds the 8-entry register file.
- On a start request, sequences two register reads: Rn goes to the A latch; Rm goes through a 1-bit shifter (or an immediate is selected) to the B latch.
- Then presents Ain/Bin/ALUop with a valid/ready handshake to the ALU and its result-capture logic.
- The register file's write port is driven by the downstream write-back path.

---
 rtl/operand_fetch_pkg.sv | 29 ++
 rtl/operand_fetch_reg_file.sv | 37 +++
 rtl/operand_fetch.sv | 136 +++++++++++++
 tb/tb_operand_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage and the ALU it feeds:
// datapath sizes, ALU op / shift encodings and the fetch FSM states.
package operand_fetch_pkg;

    localparam int OF_WIDTH = 16;
    localparam int OF_NREGS = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD_A = 2'b01,
        ST_LOAD_B = 2'b10,
        ST_VALID  = 2'b11
    } of_state_e;

endpackage

// File: rtl/operand_fetch_reg_file.sv
// General register file: NREGS x WIDTH, async reset to zero,
// one synchronous write port, two combinational read ports.
//   i/o: clk, rst_n, wr_en/wr_addr/wr_data, ra_addr->ra_data, rb_addr->rb_data
module operand_fetch_reg_file
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = OF_WIDTH,
    parameter int NREGS = OF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign ra_data = r_mem[ra_addr];
    assign rb_data = r_mem[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: captures an instruction on start, reads Rn into A,
// then Rm (1-bit shifted) or imm into B, and holds them valid until taken.
//   in : clk, rst_n, start, rn, rm, shift, use_imm, imm, op_in,
//        wr_en, wr_addr, wr_data, out_ready
//   out: Ain, Bin, ALUop, valid, busy
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = OF_WIDTH,
    parameter int NREGS = OF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    input  logic [1:0]       shift,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       op_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Ain,
    output logic [WIDTH-1:0] Bin,
    output logic [1:0]       ALUop,
    output logic             valid,
    output logic             busy
);

    of_state_e        r_state;
    of_state_e        w_state_nxt;

    logic [AW-1:0]    r_rn;
    logic [AW-1:0]    r_rm;
    shift_e           r_shift;
    logic             r_use_imm;
    logic [WIDTH-1:0] r_imm;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_rf_a;
    logic [WIDTH-1:0] w_rf_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_b_nxt;

    operand_fetch_reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ra_addr (r_rn),
        .ra_data (w_rf_a),
        .rb_addr (r_rm),
        .rb_data (w_rf_b)
    );

    // A same-edge write to the register being read wins over the old value.
    assign w_rd_a = (wr_en && wr_addr == r_rn) ? wr_data : w_rf_a;
    assign w_rd_b = (wr_en && wr_addr == r_rm) ? wr_data : w_rf_b;

    always_comb begin
        w_shifted = w_rd_b;
        unique case (r_shift)
            SH_NONE: w_shifted = w_rd_b;
            SH_LSL1: w_shifted = {w_rd_b[WIDTH-2:0], 1'b0};
            SH_LSR1: w_shifted = {1'b0, w_rd_b[WIDTH-1:1]};
            SH_ASR1: w_shifted = {w_rd_b[WIDTH-1], w_rd_b[WIDTH-1:1]};
        endcase
    end

    assign w_b_nxt = r_use_imm ? r_imm : w_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_LOAD_A;
            ST_LOAD_A: w_state_nxt = ST_LOAD_B;
            ST_LOAD_B: w_state_nxt = ST_VALID;
            ST_VALID:  if (out_ready) w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rn      <= '0;
            r_rm      <= '0;
            r_shift   <= SH_NONE;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_rn      <= rn;
                r_rm      <= rm;
                r_shift   <= shift_e'(shift);
                r_use_imm <= use_imm;
                r_imm     <= imm;
                r_op      <= alu_op_e'(op_in);
            end
            if (r_state == ST_LOAD_A) begin
                r_a <= w_rd_a;
            end
            if (r_state == ST_LOAD_B) begin
                r_b <= w_b_nxt;
            end
        end
    end

    assign Ain   = r_a;
    assign Bin   = r_b;
    assign ALUop = r_op;
    assign valid = (r_state == ST_VALID);
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: transaction-level model,
// per-cycle compare, directed literal checks and a random soak.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic        use_imm;
    logic [15:0] imm;
    logic [1:0]  op_in;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        out_ready;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [1:0]  ALUop;
    logic        valid;
    logic        busy;

    int n_pass;
    int n_total;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .use_imm   (use_imm),
        .imm       (imm),
        .op_in     (op_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_ready (out_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .valid     (valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a fetch is "phase" cycles old (0 = none in flight).
    logic [15:0] mreg [8];
    int          m_phase;
    logic [2:0]  q_rn, q_rm;
    logic [1:0]  q_sh, q_op;
    logic        q_ui;
    logic [15:0] q_imm;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_op;

    // Value a read sees at an edge: a simultaneous write is visible.
    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic [15:0] m_shift(input logic [15:0] x,
                                           input logic [1:0] s);
        case (s)
            2'd1:    return 16'(x * 2);
            2'd2:    return x / 2;
            2'd3:    return 16'($signed(x) >>> 1);
            default: return x;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            for (int i = 0; i < 8; i++) mreg[i] = '0;
            m_a = '0; m_b = '0; m_op = '0;
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    q_rn = rn; q_rm = rm; q_sh = shift; q_ui = use_imm;
                    q_imm = imm; q_op = op_in; m_op = op_in;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_a = m_read(q_rn);
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_b = q_ui ? q_imm : m_shift(m_read(q_rm), q_sh);
                m_phase = 3;
            end else if (out_ready) begin
                m_phase = 0;
            end
            if (wr_en) mreg[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
            chk("valid", {31'd0, valid}, {31'd0, m_phase == 3});
            chk("Ain", {16'd0, Ain}, {16'd0, m_a});
            chk("Bin", {16'd0, Bin}, {16'd0, m_b});
            chk("ALUop", {30'd0, ALUop}, {30'd0, m_op});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issue one fetch and return in the first cycle valid is high.
    task automatic fetch(input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] sh, input logic ui,
                         input logic [15:0] im, input logic [1:0] op);
        int n;
        start = 1'b1; rn = a; rm = b; shift = sh; use_imm = ui;
        imm = im; op_in = op;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            rn = 3'($urandom); rm = 3'($urandom); imm = 16'($urandom);
            n++;
        end while (!valid && n < 10);
        chk("latency", n, 3);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released_valid", {31'd0, valid}, 0);
        chk("released_busy", {31'd0, busy}, 0);
    endtask

    logic [15:0] sh_exp [3];

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 0; rn = 0; rm = 0; shift = 0; use_imm = 0;
        imm = 0; op_in = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        out_ready = 0;
        sh_exp[0] = 16'h0006; sh_exp[1] = 16'h4001; sh_exp[2] = 16'hC001;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_Ain", {16'd0, Ain}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(3'd1, 16'h0005);
        wr(3'd2, 16'h0003);
        fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 2'b01);
        chk("basic_Ain", {16'd0, Ain}, 32'h0005);
        chk("basic_Bin", {16'd0, Bin}, 32'h0003);
        chk("basic_op", {30'd0, ALUop}, 32'd1);
        release_out();

        wr(3'd2, 16'h8003);
        for (int s = 1; s < 4; s++) begin
            fetch(3'd1, 3'd2, 2'(s), 1'b0, 16'h0, 2'b00);
            chk($sformatf("shift%0d_Bin", s), {16'd0, Bin},
                {16'd0, sh_exp[s-1]});
            release_out();
        end

        fetch(3'd1, 3'd2, 2'b11, 1'b1, 16'h1234, 2'b10);
        chk("imm_Bin", {16'd0, Bin}, 32'h1234);
        chk("imm_op", {30'd0, ALUop}, 32'd2);
        release_out();

        fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 2'b11);
        for (int i = 0; i < 5; i++) begin
            start = 1'(i % 2 == 0); rn = 3'd6; op_in = 2'b00;
            @(negedge clk);
            chk("bp_valid", {31'd0, valid}, 1);
            chk("bp_Ain", {16'd0, Ain}, 32'h0005);
            chk("bp_Bin", {16'd0, Bin}, 32'h8003);
            chk("bp_op", {30'd0, ALUop}, 32'd3);
        end
        start = 1'b0;
        release_out();

        start = 1'b1; rn = 3'd4; rm = 3'd5; shift = 0; use_imm = 0;
        op_in = 0;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("byp_valid", {31'd0, valid}, 1);
        chk("byp_Ain", {16'd0, Ain}, 32'hBEEF);
        release_out();
        fetch(3'd4, 3'd4, 2'b10, 1'b0, 16'h0, 2'b00);
        chk("rnrm_Ain", {16'd0, Ain}, 32'hBEEF);
        chk("rnrm_Bin", {16'd0, Bin}, 32'h5F77);
        release_out();

        start = 1'b1; rn = 3'd1; rm = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_Ain", {16'd0, Ain}, 0);
        chk("midrst_Bin", {16'd0, Bin}, 0);
        chk("midrst_op", {30'd0, ALUop}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 2'b00);
        chk("postrst_Ain", {16'd0, Ain}, 0);
        chk("postrst_Bin", {16'd0, Bin}, 0);
        release_out();

        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 3) == 0;
            rn = 3'($urandom); rm = 3'($urandom);
            shift = 2'($urandom); use_imm = 1'($urandom);
            imm = 16'($urandom); op_in = 2'($urandom);
            wr_en = 1'($urandom); wr_addr = 3'($urandom);
            wr_data = 16'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
